// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for a single-ported fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ready,
  output logic [DW-1:0] rdata,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_ready;
  logic [1:0]    r_grant;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          w_win;
`ifdef MEM_ARB_RR_EN
  logic          r_last;
  assign w_win = &req ? ~r_last : req[1];
`else
  assign w_win = ~req[0];
`endif
  assign ready     = r_ready;
  assign rdata     = r_rdata;
  assign grant     = r_grant;
  assign busy      = r_state != IDLE;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_win    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ready  <= '0;
      r_grant  <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last   <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_win    <= w_win;
          r_we     <= we[w_win];
          r_addr   <= w_win ? addr1 : addr0;
          r_wdata  <= w_win ? wdata1 : wdata0;
          r_grant  <= w_win ? 2'b10 : 2'b01;
          r_mem_en <= 1'b1;
          r_mem_we <= we[w_win];
          r_state  <= ACCESS;
        end
        ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= 4'(LATENCY);
          r_state  <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rdata <= r_we ? '0 : mem_rdata;
            r_ready <= r_win ? 2'b10 : 2'b01;
            r_state <= RESP;
          end
        end
        default: begin
          r_ready <= '0;
          r_grant <= '0;
          r_rdata <= '0;
`ifdef MEM_ARB_RR_EN
          r_last  <= r_win;
`endif
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at LATENCY=2 (dut_a) and LATENCY=1 (dut_b).
module tb_mem_arbiter;
  localparam logic [31:0] K = 32'hDEADBEAF;
  localparam logic [31:0] JUNK = 32'hBAD0BAD0;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] req_a = '0, req_b = '0, we = '0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] a_ready, a_grant, b_ready, b_grant;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic a_busy, a_mem_en, a_mem_we, b_busy, b_mem_en, b_mem_we;
  logic va1 = 0, va2 = 0, vb1 = 0;
  logic [31:0] aa1 = '0, aa2 = '0, ab1 = '0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.AW(32), .DW(32), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ready(a_ready), .rdata(a_rdata), .grant(a_grant),
    .busy(a_busy), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));
  mem_arbiter #(.AW(32), .DW(32), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ready(b_ready), .rdata(b_rdata), .grant(b_grant),
    .busy(b_busy), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));
  // memory models: read data valid only in the exact cycle LATENCY after mem_en
  always @(posedge clk) begin
    va1 <= a_mem_en && !a_mem_we;
    aa1 <= a_mem_addr;
    va2 <= va1;
    aa2 <= aa1;
    vb1 <= b_mem_en && !b_mem_we;
    ab1 <= b_mem_addr;
  end
  assign a_mem_rdata = va2 ? aa2 ^ K : JUNK;
  assign b_mem_rdata = vb1 ? ab1 ^ K : JUNK;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_a(input string tag);
    check({tag, " busy"}, 64'(a_busy), 0);
    check({tag, " grant"}, 64'(a_grant), 0);
    check({tag, " ready"}, 64'(a_ready), 0);
    check({tag, " mem_en"}, 64'(a_mem_en), 0);
  endtask
  initial begin
    tick();
    tick();
    idle_a("rst");
    check("rst mem_addr", 64'(a_mem_addr), 0);
    check("rst rdata", 64'(a_rdata), 0);
    check("rst b busy", 64'(b_busy), 0);
    reset = 1'b1;
    tick();
    // single core read, LATENCY=2
    req_a = 2'b01; addr0 = 32'h40; addr1 = 32'h44; wdata0 = 32'h1111; wdata1 = 32'h2222;
    tick();
    check("rd c1 mem_en", 64'(a_mem_en), 1);
    check("rd c1 mem_we", 64'(a_mem_we), 0);
    check("rd c1 mem_addr", 64'(a_mem_addr), 32'h40);
    check("rd c1 grant", 64'(a_grant), 2'b01);
    check("rd c1 busy", 64'(a_busy), 1);
    tick();
    check("rd c2 mem_en", 64'(a_mem_en), 0);
    check("rd c2 ready", 64'(a_ready), 0);
    tick();
    check("rd c3 ready", 64'(a_ready), 0);
    check("rd c3 grant", 64'(a_grant), 2'b01);
    tick();
    check("rd c4 ready", 64'(a_ready), 2'b01);
    check("rd c4 rdata", 64'(a_rdata), 32'hDEADBEEF);
    check("rd c4 grant", 64'(a_grant), 2'b01);
    req_a = 2'b00;
    tick();
    idle_a("rd c5");
    // DMA write
    req_a = 2'b10; we = 2'b10; addr1 = 32'h80; wdata1 = 32'h12345678;
    tick();
    check("wr c1 mem_en", 64'(a_mem_en), 1);
    check("wr c1 mem_we", 64'(a_mem_we), 1);
    check("wr c1 mem_addr", 64'(a_mem_addr), 32'h80);
    check("wr c1 mem_wdata", 64'(a_mem_wdata), 32'h12345678);
    check("wr c1 grant", 64'(a_grant), 2'b10);
    tick();
    check("wr c2 mem_en", 64'(a_mem_en), 0);
    check("wr c2 mem_we", 64'(a_mem_we), 0);
    tick();
    tick();
    check("wr c4 ready", 64'(a_ready), 2'b10);
    check("wr c4 rdata", 64'(a_rdata), 0);
    req_a = 2'b00; we = 2'b00;
    tick();
    idle_a("wr c5");
    // tie after reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_a = 2'b11; addr0 = 32'h40; addr1 = 32'h100;
    tick();
    check("tie c1 grant", 64'(a_grant), 2'b01);
    tick(); tick(); tick();
    check("tie c4 ready", 64'(a_ready), 2'b01);
    req_a = 2'b10;
    tick();
    idle_a("tie c5");
    tick();
    check("tie c6 grant", 64'(a_grant), 2'b10);
    check("tie c6 mem_addr", 64'(a_mem_addr), 32'h100);
    tick(); tick(); tick();
    check("tie c9 ready", 64'(a_ready), 2'b10);
    check("tie c9 rdata", 64'(a_rdata), 32'h100 ^ K);
    req_a = 2'b00;
    tick();
    // continuous requests from both ports
    req_a = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont grant", 64'(a_grant), (RR && i % 2 == 1) ? 2'b10 : 2'b01);
      tick(); tick(); tick();
      check("cont ready", 64'(a_ready), (RR && i % 2 == 1) ? 2'b10 : 2'b01);
      if (i == 3) req_a = 2'b00;
      tick();
      check("cont idle", 64'(a_busy), 0);
    end
    // reset during WAIT
    req_a = 2'b01; addr0 = 32'h44;
    tick();
    tick();
    check("rst wait busy", 64'(a_busy), 1);
    reset = 1'b0;
    tick();
    idle_a("rst mid");
    check("rst mid mem_addr", 64'(a_mem_addr), 0);
    check("rst mid rdata", 64'(a_rdata), 0);
    reset = 1'b1; req_a = 2'b00;
    tick();
    check("rst post ready", 64'(a_ready), 0);
    req_a = 2'b01;
    tick();
    check("post c1 mem_en", 64'(a_mem_en), 1);
    tick(); tick();
    check("post c3 ready", 64'(a_ready), 0);
    tick();
    check("post c4 ready", 64'(a_ready), 2'b01);
    check("post c4 rdata", 64'(a_rdata), 32'h44 ^ K);
    req_a = 2'b00;
    tick();
    // LATENCY=1 boundary on dut_b
    req_b = 2'b01; addr0 = 32'h48;
    tick();
    check("l1 c1 mem_en", 64'(b_mem_en), 1);
    tick();
    check("l1 c2 busy", 64'(b_busy), 1);
    check("l1 c2 ready", 64'(b_ready), 0);
    tick();
    check("l1 c3 ready", 64'(b_ready), 2'b01);
    check("l1 c3 rdata", 64'(b_rdata), 32'h48 ^ K);
    req_b = 2'b00;
    tick();
    check("l1 c4 busy", 64'(b_busy), 0);
    check("l1 a idle", 64'(a_busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-ported unified instruction/data memory of the multicycle RISC-V core. It accepts memory requests from the core's memory-interface port (port 0) and from a DMA/debug port (port 1). It grants one requester at a time, drives a fixed-latency memory for exactly one access, and returns the response to the winner with a one-cycle `ready` pulse. It sits between the core's `AdrSrc`-selected address path and the memory macro.

## Interface
- `AW`, default 32, address width.
- `DW`, default 32, data width.
- `LATENCY`, default 1, memory read latency in cycles, measured from the `mem_en` cycle to the cycle `mem_rdata` is valid; legal range 1..15.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: reset, synchronous and active-low (asserted when 0).
- `req[1:0]` in 2: per-port request; bit 0 is the core, bit 1 is DMA.
- `we[1:0]` in 2: per-port write enable.
- `addr0`, `addr1` in AW: per-port address.
- `wdata0`, `wdata1` in DW: per-port write data.
- `ready[1:0]` out 2: one-cycle response pulse to the granted port.
- `rdata` out DW: read data, valid while any `ready` bit is 1.
- `grant[1:0]` out 2: one-hot owner of the current access; 0 when idle.
- `busy` out 1: high in every state except IDLE.
- `mem_en` out 1: single-cycle memory access strobe.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data.

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT and RESP.
- **IDLE:**
  - If any `req` bit is 1, pick a winner.
  - Latch the winner's `we`, `addr` and `wdata`; set `grant`; go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS** (1 cycle):
  - `mem_en`=1 and `mem_we`=latched `we`.
  - Load the counter with LATENCY; go to WAIT.
- **WAIT** (LATENCY cycles):
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, register `mem_rdata` into `rdata` (for reads only), then go to RESP.
- **RESP** (1 cycle):
  - `ready[winner]`=1; record the winner in `last_grant`; go to IDLE.
  - `req` is not sampled in RESP.
- Arbitration when only one `req` bit is set: that port wins.
- Arbitration when both `req` bits are set: the port that is not `last_grant` wins.
  - `last_grant` resets to 1, so the core wins the first tie.
- `mem_addr` and `mem_wdata` always reflect the latched values.
- `mem_en` and `mem_we` are 0 outside ACCESS.
- `grant` holds its value from ACCESS through RESP and is 0 in IDLE.
- For writes, `rdata` is 0 during RESP.
- **Requester rule:**
  - Hold `req`, `we`, `addr` and `wdata` stable until `ready` is seen.
  - Drop `req` on the edge that samples `ready`.
  - If `req` is still high in the next IDLE cycle, it is a new request.
- A `req` that falls before `ready` does not abort the access in progress; the access completes and the `ready` pulse is still issued.

## Timing
- Reset values (applied at any clock edge with `reset`=0, including mid-access):
  - State IDLE, `last_grant`=1, counter 0.
  - `ready`, `grant`, `busy`, `mem_en` and `mem_we` all 0.
  - `rdata`, `mem_addr` and `mem_wdata` all 0.
  - No `ready` pulse is issued for an aborted access.
- Latency, taking cycle 0 as the IDLE cycle in which `req` is sampled:
  - `mem_en` in cycle 1.
  - `mem_rdata` sampled in cycle 1+LATENCY.
  - `ready` in cycle LATENCY+2.
- Throughput: at most one access per LATENCY+3 cycles. Back-to-back grants are separated by exactly one IDLE cycle.
- Simultaneous `req` edges are resolved by the arbitration rule in a single IDLE cycle. The losing port is never given a partial access.
- The counter is 4 bits wide. LATENCY=1 gives exactly one WAIT cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break using `last_grant`, as in Operation.
- `MEM_ARB_RR_EN` undefined: fixed priority; the core (port 0) always wins a tie and `last_grant` is unused. With this setting, sustained core traffic starves DMA.

## Test plan
- **Single read, LATENCY=2:** core `req`=1, `addr0`=0x40, memory returns 0xDEADBEEF → `mem_en` high in cycle 1, `ready[0]`=1 in cycle 4 with `rdata`=0xDEADBEEF, `grant`=01 in cycles 1–4.
- **DMA write:** `req[1]`=1, `we[1]`=1, `addr1`=0x80, `wdata1`=0x12345678 → `mem_en`=`mem_we`=1 for exactly one cycle with `mem_addr`=0x80 and `mem_wdata`=0x12345678; `ready[1]` in cycle LATENCY+2; `rdata`=0.
- **Tie after reset, LATENCY=2:** both `req` bits rise in cycle 0 → `ready[0]` in cycle 4, then DMA sampled in cycle 5 and `ready[1]` in cycle 9.
- **Continuous requests from both ports for 4 accesses:** with `MEM_ARB_RR_EN` the grants run 01,10,01,10; without it every grant is 01.
- **Reset mid-access:** drop `reset` to 0 during WAIT → the next cycle shows IDLE with all outputs 0 and no `ready`; the first request after reset follows the normal timing.
- **LATENCY=1 boundary:** single core read → exactly one WAIT cycle and `ready` in cycle 3.
